// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MEM-stage data memory.
package mips_mem_pkg;

   localparam int unsigned WORD_W      = 32;
   localparam int unsigned MAX_LATENCY = 15;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mem_state_e;

   // Byte address is not word aligned.
   function automatic logic misaligned(input logic [1:0] lsb);
      return lsb != 2'b00;
   endfunction

endpackage

// File: rtl/mem_latency_counter.sv
// Read-latency cycle counter with clear, enable and terminal-count flag.
module mem_latency_counter #(
   parameter int unsigned LATENCY = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic terminal_c
);

   localparam int unsigned CNT_W = $clog2(LATENCY + 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + CNT_W'(1);
      end
   end

   assign terminal_c = (count == CNT_W'(LATENCY - 1));

endmodule

// File: rtl/data_mem_stage.sv
// MEM-stage data memory: fixed-latency loads with pipeline stall, single-cycle posted stores.
module data_mem_stage
   import mips_mem_pkg::*;
#(
   parameter int unsigned DEPTH   = 1024,
   parameter int unsigned LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WORD_W-1:0] dataMemAddress,
   input  logic [WORD_W-1:0] dataMemWriteData,
   input  logic              dataMemRead,
   input  logic              dataMemWrite,
   output logic [WORD_W-1:0] dataMemReadData,
   output logic              memStall,
   output logic              memErr
);

   localparam int unsigned AW  = $clog2(DEPTH);
   localparam int unsigned LAT = (LATENCY > MAX_LATENCY) ? MAX_LATENCY :
                                 ((LATENCY == 0) ? 1 : LATENCY);

   mem_state_e        state;
   mem_state_e        state_next;
   logic [AW-1:0]     index_c;
   logic              accept_c;
   logic              write_en_c;
   logic              capture_c;
   logic              stall_c;
   logic              err_set_c;
   logic              terminal_c;
   logic              unused_addr_c;
   logic [WORD_W-1:0] mem_array [DEPTH];

   // Upper address bits wrap around the array.
   assign index_c       = dataMemAddress[AW+1:2];
   assign unused_addr_c = ^dataMemAddress[WORD_W-1:AW+2];

   mem_latency_counter #(
      .LATENCY (LAT)
   ) u_lat_cnt (
      .clk        (clk),
      .rst_n      (rst),
      .clear      (accept_c),
      .enable     (state == BUSY),
      .terminal_c (terminal_c)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state           <= IDLE;
         dataMemReadData <= '0;
         memErr          <= 1'b0;
      end else begin
         state <= state_next;
         if (capture_c) begin
            dataMemReadData <= mem_array[index_c];
         end
         if (err_set_c) begin
            memErr <= 1'b1;
         end
      end
   end

   // Storage is not reset.
   always_ff @(posedge clk) begin
      if (write_en_c) begin
         mem_array[index_c] <= dataMemWriteData;
      end
   end

   always_comb begin
      state_next = state;
      accept_c   = 1'b0;
      write_en_c = 1'b0;
      capture_c  = 1'b0;
      stall_c    = 1'b0;
      err_set_c  = 1'b0;
      case (state)
         IDLE: begin
            // A write wins over a simultaneous read, which is flagged.
            if (dataMemWrite) begin
               write_en_c = 1'b1;
               err_set_c  = dataMemRead | misaligned(dataMemAddress[1:0]);
            end else if (dataMemRead) begin
               accept_c   = 1'b1;
               stall_c    = 1'b1;
               state_next = BUSY;
               err_set_c  = misaligned(dataMemAddress[1:0]);
            end
         end
         BUSY: begin
            stall_c = 1'b1;
            if (!dataMemRead) begin
               state_next = IDLE;
            end else if (terminal_c) begin
               capture_c  = 1'b1;
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Gated by reset so an asserted reset drops the stall at once.
   assign memStall = rst & stall_c;

endmodule
